// File: rtl/pc_out_rr_arbiter_pkg.sv
// Shared types, width helper and harness-wide defaults for the PC-bound output arbiter.
`default_nettype none

package pc_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int NWORD_DEF   = 32;
  localparam int NPCCODE_DEF = 4;

  // Index width that never collapses to zero bits, even for a single source.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_out_rr_arbiter_rr_pick.sv
// Round-robin selector: first requester at or after ptr_i, wrapping modulo NIN.
`default_nettype none

module rr_pick
  import pc_arb_pkg::*;
#(
  parameter int NIN = 2,
  parameter int PW  = clog2_min1(NIN)
) (
  input  logic [NIN-1:0] req_i,
  input  logic [PW-1:0]  ptr_i,
  output logic [PW-1:0]  pick_o,
  output logic           any_req_o
);

  logic [NIN-1:0] w_rot;
  int             w_sel;

  always_comb begin
    w_rot = '0;
    w_sel = 0;
    for (int j = 0; j < NIN; j++) begin
      w_rot[j] = req_i[PW'((int'(ptr_i) + j) % NIN)];
    end
    // Scan downwards so the lowest rotated position, i.e. the one nearest ptr_i, wins.
    for (int j = NIN - 1; j >= 0; j--) begin
      if (w_rot[j]) w_sel = j;
    end
    pick_o    = PW'((int'(ptr_i) + w_sel) % NIN);
    any_req_o = |req_i;
  end

endmodule

`default_nettype wire

// File: rtl/pc_out_rr_arbiter.sv
// Burst-limited round-robin arbiter merging NIN word streams onto one registered output slot.
`default_nettype none

module pc_out_rr_arbiter
  import pc_arb_pkg::*;
#(
  parameter int NIN      = 2,
  parameter int NWORD    = NWORD_DEF,
  parameter int MAXBURST = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NIN-1:0]               in_v,
  input  logic [NIN*NWORD-1:0]         in_d,
  output logic [NIN-1:0]               in_a,
  output logic                         out_v,
  output logic [NWORD-1:0]             out_d,
  input  logic                         out_a,
  output logic [clog2_min1(NIN)-1:0]   grant_id,
  output logic                         busy
);

  localparam int c_pw = clog2_min1(NIN);
  localparam int c_cw = clog2_min1(MAXBURST + 1);

  state_e             state_q;
  logic [c_pw-1:0]    ptr_q;
  logic [c_pw-1:0]    grant_q;
  logic [c_cw-1:0]    cnt_q;
  logic               out_v_q;
  logic [NWORD-1:0]   out_d_q;

  logic               w_slot_free;
  logic               w_gnt_v;
  logic               w_xfer;
  logic               w_last_word;
  logic [c_pw-1:0]    w_ptr_next;
  logic [c_pw-1:0]    w_pick;
  logic               w_any_req;
  logic [NWORD-1:0]   w_sel_word;

  rr_pick #(
    .NIN (NIN),
    .PW  (c_pw)
  ) u_pick (
    .req_i     (in_v),
    .ptr_i     (ptr_q),
    .pick_o    (w_pick),
    .any_req_o (w_any_req)
  );

  always_comb begin
    w_slot_free = !out_v_q || out_a;
    w_gnt_v     = in_v[grant_q];
    in_a        = '0;
    if (reset && (state_q == GRANT) && w_slot_free) begin
      in_a = NIN'(1) << grant_q;
    end
    w_xfer      = |(in_a & in_v);
    w_last_word = (cnt_q == c_cw'(MAXBURST - 1));
    w_ptr_next  = (grant_q == c_pw'(NIN - 1)) ? '0 : grant_q + 1'b1;
    w_sel_word  = in_d[int'(grant_q)*NWORD +: NWORD];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      out_v_q <= 1'b0;
      out_d_q <= '0;
    end else begin
      if (w_xfer) begin
        out_v_q <= 1'b1;
        out_d_q <= w_sel_word;
      end else if (out_a) begin
        out_v_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          // Nothing is accepted here: every new grant costs exactly one bubble.
          if (w_any_req) begin
            grant_q <= w_pick;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!w_gnt_v) begin
            state_q <= IDLE;
            ptr_q   <= w_ptr_next;
          end else if (w_xfer) begin
            cnt_q <= cnt_q + 1'b1;
            if (w_last_word) begin
              state_q <= IDLE;
              ptr_q   <= w_ptr_next;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_v    = out_v_q;
  assign out_d    = out_d_q;
  assign grant_id = grant_q;
  assign busy     = (state_q == GRANT);

endmodule

`default_nettype wire

// File: tb/tb_pc_out_rr_arbiter.sv
// Bench: directed scenarios on a 2-source/burst-4 arbiter, randomized traffic on a 3-source/burst-2 one.
`default_nettype none

module tb_pc_out_rr_arbiter;

  localparam int NA = 2, MBA = 4, NB = 3, MBB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  drv_v   [2];
  logic [31:0] drv_d   [2][8];
  logic        drv_oa  [2];
  logic        drv_rst [2];

  logic [1:0]  a_in_a;  logic a_out_v; logic [31:0] a_out_d; logic [0:0] a_gid; logic a_busy;
  logic [2:0]  b_in_a;  logic b_out_v; logic [31:0] b_out_d; logic [1:0] b_gid; logic b_busy;

  pc_out_rr_arbiter #(.NIN(NA), .NWORD(32), .MAXBURST(MBA)) u_dut_a (
    .clk(clk), .reset(drv_rst[0]), .in_v(drv_v[0][1:0]), .in_d({drv_d[0][1], drv_d[0][0]}),
    .in_a(a_in_a), .out_v(a_out_v), .out_d(a_out_d), .out_a(drv_oa[0]), .grant_id(a_gid), .busy(a_busy));

  pc_out_rr_arbiter #(.NIN(NB), .NWORD(32), .MAXBURST(MBB)) u_dut_b (
    .clk(clk), .reset(drv_rst[1]), .in_v(drv_v[1][2:0]),
    .in_d({drv_d[1][2], drv_d[1][1], drv_d[1][0]}),
    .in_a(b_in_a), .out_v(b_out_v), .out_d(b_out_d), .out_a(drv_oa[1]), .grant_id(b_gid), .busy(b_busy));

  logic [7:0]  mon_ina [2];
  logic        mon_ov  [2];
  logic [31:0] mon_od  [2];
  int          mon_gid [2];
  logic        mon_busy[2];

  always_comb begin
    mon_ina[0] = {6'b0, a_in_a}; mon_ov[0] = a_out_v; mon_od[0] = a_out_d;
    mon_gid[0] = int'(a_gid);    mon_busy[0] = a_busy;
    mon_ina[1] = {5'b0, b_in_a}; mon_ov[1] = b_out_v; mon_od[1] = b_out_d;
    mon_gid[1] = int'(b_gid);    mon_busy[1] = b_busy;
  end

  int total = 0, bad = 0, cyc = 0;
  bit chk_en = 0;

  function automatic int nin_of(input int m); return (m == 0) ? NA : NB; endfunction
  function automatic int mb_of (input int m); return (m == 0) ? MBA : MBB; endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- reference model: who owns the channel, what sits in the slot
  int          md_own[2], md_last[2], md_taken[2], md_ptr[2];
  logic        md_bv[2];
  logic [31:0] md_bd[2];
  int          wt[2][8], st[2][8], max_ex[2];

  always @(posedge clk) begin : model
    for (int m = 0; m < 2; m++) begin
      int n, own, pk, s2, ex;
      bit slot, acc;
      n = nin_of(m);
      if (!drv_rst[m]) begin
        md_own[m] = -1; md_last[m] = 0; md_taken[m] = 0; md_ptr[m] = 0;
        md_bv[m] = 0; md_bd[m] = 0;
        for (int s = 0; s < 8; s++) begin wt[m][s] = 0; st[m][s] = 0; end
      end else begin
        own  = md_own[m];
        slot = !md_bv[m] || drv_oa[m];
        acc  = (own >= 0) && drv_v[m][own] && slot;
        pk   = -1;
        if (own < 0)
          for (int k = 0; k < n; k++) begin
            s2 = (md_ptr[m] + k) % n;
            if (pk < 0 && drv_v[m][s2]) pk = s2;
          end
        for (int s = 0; s < n; s++)
          if (drv_v[m][s] && own != s) begin
            if (pk == s) begin
              ex = wt[m][s] - st[m][s];
              if (ex > max_ex[m]) max_ex[m] = ex;
              wt[m][s] = 0; st[m][s] = 0;
            end else begin
              wt[m][s]++;
              if (own >= 0 && drv_v[m][own] && !slot) st[m][s]++;
            end
          end
        if (acc) begin md_bv[m] = 1; md_bd[m] = drv_d[m][own]; end
        else if (drv_oa[m]) md_bv[m] = 0;
        if (own < 0) begin
          if (pk >= 0) begin md_own[m] = pk; md_last[m] = pk; md_taken[m] = 0; end
        end else if (!drv_v[m][own]) begin
          md_ptr[m] = (own + 1) % n; md_own[m] = -1;
        end else if (acc) begin
          md_taken[m]++;
          if (md_taken[m] == mb_of(m)) begin md_ptr[m] = (own + 1) % n; md_own[m] = -1; end
        end
      end
    end
  end

  // ---------------- compare process + output capture
  logic [31:0] strm_a[$];
  int          stamp_a[$];
  int          rx_seq[3];

  always @(negedge clk) begin : compare
    logic [7:0] ea;
    int s;
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        ea = '0;
        for (int i = 0; i < nin_of(m); i++)
          if (md_own[m] == i && drv_rst[m] && (!md_bv[m] || drv_oa[m])) ea[i] = 1'b1;
        chk($sformatf("in_a[%0d]", m),  32'(mon_ina[m]), 32'(ea));
        chk($sformatf("out_v[%0d]", m), 32'(mon_ov[m]),  32'(md_bv[m]));
        chk($sformatf("out_d[%0d]", m), mon_od[m],       md_bd[m]);
        chk($sformatf("gid[%0d]", m),   32'(mon_gid[m]), 32'(md_last[m]));
        chk($sformatf("busy[%0d]", m),  32'(mon_busy[m]), 32'(md_own[m] >= 0));
      end
      if (mon_ov[0] && drv_oa[0]) begin strm_a.push_back(mon_od[0]); stamp_a.push_back(cyc); end
      if (mon_ov[1] && drv_oa[1]) begin
        s = int'(mon_od[1][23:16]);
        if (s < NB) begin
          chk("b_seq", {16'h0, mon_od[1][15:0]}, 32'(rx_seq[s]));
          rx_seq[s]++;
        end else chk("b_src", 32'(s), 32'(NB - 1));
      end
    end
  end

  // ---------------- source/sink drivers
  int          left[2][8], idx[2][8];
  logic [31:0] base[2][8];
  bit          rnd[2];

  task automatic step();
    logic [7:0] acc [2];
    @(negedge clk);
    for (int m = 0; m < 2; m++) acc[m] = drv_v[m] & mon_ina[m];
    @(posedge clk); #1;
    for (int m = 0; m < 2; m++)
      for (int s = 0; s < nin_of(m); s++) begin
        if (acc[m][s]) begin idx[m][s]++; left[m][s]--; drv_v[m][s] = 1'b0; end
        if (!drv_v[m][s] && left[m][s] > 0 && (!rnd[m] || $urandom_range(0, 99) < 60))
          drv_v[m][s] = 1'b1;
        drv_d[m][s] = base[m][s] + 32'(idx[m][s]);
      end
    if (rnd[1]) drv_oa[1] = ($urandom_range(0, 99) < 70);
  endtask

  task automatic load(input int m, input int s, input logic [31:0] b, input int n);
    base[m][s] = b; idx[m][s] = 0; left[m][s] = n;
  endtask

  task automatic reset_a();
    for (int s = 0; s < 8; s++) begin left[0][s] = 0; idx[0][s] = 0; drv_v[0][s] = 1'b0; end
    drv_oa[0] = 1'b1; drv_rst[0] = 1'b0;
    step(); step();
    drv_rst[0] = 1'b1;
    strm_a.delete(); stamp_a.delete();
  endtask

  task automatic run_until_a(input int n, input int lim, input string nm);
    int k = 0;
    while (strm_a.size() < n && k < lim) begin step(); k++; end
    chk(nm, 32'(strm_a.size()), 32'(n));
  endtask

  // Alternating 4-word bursts from two streams with given bases.
  function automatic logic [31:0] alt_word(input int k, input logic [31:0] b0, input logic [31:0] b1);
    int burst = k / 4;
    return ((burst % 2) ? b1 : b0) + 32'((burst / 2) * 4 + k % 4);
  endfunction

  initial begin : wdog
    #5_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin : main
    logic [31:0] hold, w4[10];
    int k;
    bit seen1;
    for (int m = 0; m < 2; m++) begin
      drv_v[m] = '0; drv_oa[m] = 1'b1; drv_rst[m] = 1'b0; rnd[m] = 0; max_ex[m] = 0;
      for (int s = 0; s < 8; s++) begin drv_d[m][s] = '0; left[m][s] = 0; idx[m][s] = 0; base[m][s] = '0; end
    end
    for (int s = 0; s < 3; s++) rx_seq[s] = 0;
    repeat (3) step();
    drv_rst[0] = 1'b1; drv_rst[1] = 1'b1;
    chk("rst_out_v",  32'(a_out_v), 0);
    chk("rst_out_d",  a_out_d, 0);
    chk("rst_busy",   32'(a_busy), 0);
    chk("rst_gid",    32'(b_gid), 0);
    chk("rst_in_a",   32'(b_in_a), 0);
    chk_en = 1;

    // single source stream
    reset_a();
    load(0, 0, 32'hA0, 10);
    seen1 = 0; k = 0;
    while (strm_a.size() < 10 && k < 60) begin step(); k++; if (a_in_a[1]) seen1 = 1; end
    chk("t1_count", 32'(strm_a.size()), 10);
    chk("t1_in_a1", 32'(seen1), 0);
    for (int i = 0; i < strm_a.size(); i++) begin
      chk("t1_word", strm_a[i], 32'hA0 + 32'(i));
      chk("t1_gap",  32'(stamp_a[i] - stamp_a[0]), 32'(i + i / 4));
    end

    // two continuous sources
    reset_a();
    load(0, 0, 32'h100, 12); load(0, 1, 32'h200, 12);
    run_until_a(16, 60, "t2_count");
    for (int i = 0; i < strm_a.size(); i++) begin
      chk("t2_word", strm_a[i], alt_word(i, 32'h100, 32'h200));
      chk("t2_gap",  32'(stamp_a[i] - stamp_a[0]), 32'(i + i / 4));
    end

    // downstream backpressure mid-burst
    reset_a();
    load(0, 0, 32'h500, 12); load(0, 1, 32'h600, 12);
    repeat (4) step();
    drv_oa[0] = 1'b0;
    hold = a_out_d;
    chk("t3_pre_v", 32'(a_out_v), 1);
    repeat (5) begin
      step();
      chk("t3_hold_v", 32'(a_out_v), 1);
      chk("t3_hold_d", a_out_d, hold);
      chk("t3_in_a",   32'(a_in_a), 0);
    end
    drv_oa[0] = 1'b1;
    run_until_a(16, 80, "t3_count");
    for (int i = 0; i < strm_a.size(); i++) chk("t3_word", strm_a[i], alt_word(i, 32'h500, 32'h600));

    // source 1 goes idle after two words
    reset_a();
    load(0, 0, 32'h300, 8); load(0, 1, 32'h400, 2);
    w4 = '{32'h300, 32'h301, 32'h302, 32'h303, 32'h400, 32'h401, 32'h304, 32'h305, 32'h306, 32'h307};
    run_until_a(10, 60, "t4_count");
    for (int i = 0; i < strm_a.size(); i++) chk("t4_word", strm_a[i], w4[i]);
    repeat (4) step();
    chk("t4_src1_taken", 32'(idx[0][1]), 2);

    // reset in the middle of source 1's burst
    reset_a();
    load(0, 0, 32'h700, 40); load(0, 1, 32'h800, 40);
    k = 0;
    while (!(a_gid == 1'b1 && a_busy && a_out_v && a_out_d[11:8] == 4'h8) && k < 40) begin step(); k++; end
    chk("t5_reach", 32'(k < 40), 1);
    drv_rst[0] = 1'b0;
    #1 chk("t5_rst_in_a", 32'(a_in_a), 0);
    step();
    drv_rst[0] = 1'b1;
    chk("t5_out_v", 32'(a_out_v), 0);
    chk("t5_busy",  32'(a_busy), 0);
    chk("t5_in_a",  32'(a_in_a), 0);
    strm_a.delete(); stamp_a.delete();
    step();
    chk("t5_gid",   32'(a_gid), 0);
    run_until_a(1, 20, "t5_count");
    if (strm_a.size() > 0) chk("t5_first_src", {28'h0, strm_a[0][11:8]}, 32'h7);

    // randomized traffic on the 3-source instance
    rnd[1] = 1;
    for (int s = 0; s < NB; s++) load(1, s, 32'(s) << 16, 1_000_000);
    repeat (10000) step();
    for (int s = 0; s < NB; s++) left[1][s] = 0;
    rnd[1] = 0; drv_oa[1] = 1'b1;
    repeat (30) step();
    for (int s = 0; s < NB; s++) begin
      chk($sformatf("b_count%0d", s), 32'(rx_seq[s]), 32'(idx[1][s]));
      total++;
      if (idx[1][s] < 500) begin bad++; $display("FAIL b_traffic%0d got=%0d want>=500", s, idx[1][s]); end
    end
    total++;
    if (max_ex[1] > (NB - 1) * (MBB + 1)) begin
      bad++; $display("FAIL b_fair got=%0d want<=%0d", max_ex[1], (NB - 1) * (MBB + 1));
    end
    total++;
    if (max_ex[0] > (NA - 1) * (MBA + 1)) begin
      bad++; $display("FAIL a_fair got=%0d want<=%0d", max_ex[0], (NA - 1) * (MBA + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
